fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset==0 immediately forces reset state.
REQ-004 PC_Write  input  1  hazard-unit enable; 1 = downstream IF/ID register captures the queue head this edge.
REQ-005 Branch_Taken  input  1  branch redirect request.
REQ-006 Branch_Target  input  32  branch destination address.
REQ-007 Jump  input  1  jump redirect request.
REQ-008 Jump_Target  input  32  jump destination address.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  32  instruction-memory address.
REQ-011 imem_ready  input  1  memory completes the request this edge; imem_rdata valid.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 fetch_valid  output  1  queue non-empty; head outputs hold a real instruction.
REQ-014 PC_plus4_out  output  32  head entry fetch address + 4; 0 when queue empty.
REQ-015 instruction_out  output  32  head entry instruction; 32'h0 (NOP) when queue empty.

Function
REQ-016 The block SHALL hold a 32-bit PC register, a 32-bit redirect_pc register, a 2-entry in-order queue of {PC+4, instruction}, and a 2-bit count (0..2).
REQ-017 FSM states SHALL be IDLE (imem_req=0), REQ (imem_req=1), DRAIN (imem_req=1, result discarded); imem_addr SHALL equal PC in all states.
REQ-018 Once imem_req is 1, imem_addr SHALL remain stable until the edge where imem_ready==1 (transfer).
REQ-019 redirect = Branch_Taken | Jump; target = Branch_Target if Branch_Taken, else Jump_Target (branch has priority).
REQ-020 pop = fetch_valid & PC_Write & ~redirect; a pop removes the head at the edge.
REQ-021 IDLE: redirect -> PC<=target, queue flushed, stay IDLE; else count<2 -> REQ; else stay IDLE.
REQ-022 REQ, transfer, no redirect: push {PC+4, imem_rdata}, PC<=PC+4; next state REQ if (count-pop+1)<2, else IDLE.
REQ-023 REQ, transfer with redirect: data discarded, queue flushed, PC<=target, stay REQ.
REQ-024 REQ, no transfer, redirect: redirect_pc<=target, queue flushed, PC unchanged, go to DRAIN.
REQ-025 DRAIN: further redirect overwrites redirect_pc (latest wins); on transfer, data discarded, PC<=redirect_pc, go to REQ.
REQ-026 Any redirect SHALL flush the queue (count<=0) regardless of PC_Write; the head is not popped that edge.
REQ-027 Simultaneous push and pop SHALL leave count unchanged with order preserved; push never occurs at count==2 (guaranteed by REQ-021/022).
REQ-028 PC arithmetic SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-029 Latency: zero-wait memory (imem_ready tied 1) SHALL sustain one push per cycle; first fetch_valid two cycles after reset release.

Reset
REQ-030 reset==0 SHALL asynchronously set PC=RESET_PC, redirect_pc=0, count=0, state=IDLE, imem_req=0, fetch_valid=0, PC_plus4_out=0, instruction_out=0.
REQ-031 Reset asserted mid-request SHALL drop imem_req immediately; the pending transfer is abandoned, no entry pushed.
REQ-032 After reset release, first request SHALL be issued for RESET_PC.

Verification
REQ-033 Reset release, imem_ready=1, PC_Write=1, rdata=addr -> imem_addr 0,4,8,...; instruction_out 0,4,8 on successive cycles; PC_plus4_out 4,8,12.
REQ-034 PC_Write=0 for 5 cycles, imem_ready=1 -> count reaches 2, state IDLE, imem_req=0, head stays addr 0 entry; PC_Write=1 -> entries drain in order, fetching resumes at 8.
REQ-035 imem_ready=0 for 3 cycles on addr 0x10, Branch_Taken=1 target 0x40 in cycle 1 -> DRAIN, imem_addr stays 0x10; on ready, data dropped, next imem_addr 0x40, fetch_valid=0 until 0x40 returns.
REQ-036 Branch_Taken=1 (0x80) and Jump=1 (0x200) same cycle -> next fetch address 0x80.
REQ-037 PC=32'hFFFFFFFC, transfer -> PC_plus4_out=0, next imem_addr=0.
REQ-038 reset pulsed low while imem_req=1 and count=1 -> imem_req, fetch_valid, instruction_out drop to 0 without clock edge; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, imem request handshake and a
// 2-entry in-order queue of {PC+4, instruction} feeding the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] PC_plus4_out,
  output logic [31:0] instruction_out
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  state_t      state;
  logic [31:0] pc, redirect_pc;
  entry_t      q0, q1;
  logic [1:0]  count;

  logic        redirect, transfer, pop, push;
  logic [31:0] target, pc_plus4;
  logic [2:0]  fill;
  entry_t      new_entry;

  assign redirect  = Branch_Taken | Jump;
  assign target    = Branch_Taken ? Branch_Target : Jump_Target;
  assign transfer  = (state != IDLE) & imem_ready;
  assign pop       = fetch_valid & PC_Write & ~redirect;
  assign push      = (state == REQ) & transfer & ~redirect;
  assign pc_plus4  = pc + 32'd4;
  assign new_entry = '{pc4: pc_plus4, instr: imem_rdata};
  // occupancy after this edge's pop and push; decides whether to keep requesting
  assign fill      = {1'b0, count} - {2'b00, pop} + 3'd1;

  assign imem_req        = (state != IDLE);
  assign imem_addr       = pc;
  assign fetch_valid     = (count != 2'd0);
  assign PC_plus4_out    = fetch_valid ? q0.pc4   : 32'h0;
  assign instruction_out = fetch_valid ? q0.instr : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      redirect_pc <= 32'h0;
      count       <= 2'd0;
      q0          <= '0;
      q1          <= '0;
    end else begin
      if (redirect) begin
        count <= 2'd0;
      end else if (push && pop) begin
        if (count == 2'd2) begin
          q0 <= q1;
          q1 <= new_entry;
        end else begin
          q0 <= new_entry;
        end
      end else if (pop) begin
        q0    <= q1;
        count <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) q0 <= new_entry;
        else               q1 <= new_entry;
        count <= count + 2'd1;
      end

      case (state)
        IDLE: begin
          if (redirect)              pc    <= target;
          else if (count != 2'd2)    state <= REQ;
        end
        REQ: begin
          if (transfer) begin
            if (redirect) begin
              pc <= target;
            end else begin
              pc    <= pc_plus4;
              state <= (fill < 3'd2) ? REQ : IDLE;
            end
          end else if (redirect) begin
            // address must stay stable until the in-flight access completes
            redirect_pc <= target;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect) redirect_pc <= target;
          if (transfer) begin
            pc    <= redirect ? target : redirect_pc;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {PC+4, instr} entries are queued
// as fetch streams are launched and compared as the consumer pops them.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_Write, Branch_Taken, Jump, imem_ready;
  logic [31:0] Branch_Target, Jump_Target, imem_rdata, imem_addr;
  logic        imem_req, fetch_valid;
  logic [31:0] PC_plus4_out, instruction_out;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Jump(Jump), .Jump_Target(Jump_Target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .fetch_valid(fetch_valid), .PC_plus4_out(PC_plus4_out),
    .instruction_out(instruction_out)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ K;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [31:0] a);
    sb.push_back('{pc4: a + 32'd4, instr: a ^ K});
  endtask

  // consumer side: compare the head that will be popped at the coming edge
  task automatic cyc();
    exp_t e;
    if (fetch_valid && PC_Write && !(Branch_Taken || Jump)) begin
      if (sb.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("pc4", PC_plus4_out, e.pc4);
        chk("instr", instruction_out, e.instr);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int b = budget;
    while (sb.size() > 0 && b > 0) begin cyc(); b--; end
    chk("drain_left", 32'(sb.size()), 32'd0);
    PC_Write = 1'b0;
  endtask

  task automatic rst_seq();
    reset = 1'b0;
    PC_Write = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0; imem_ready = 1'b1;
    Branch_Target = 32'h0; Jump_Target = 32'h0;
    sb.delete();
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pc4", PC_plus4_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid_early", {31'b0, fetch_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ea;
    // streaming with zero-wait memory
    rst_seq();
    PC_Write = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    cyc();
    chk("first_valid", {31'b0, fetch_valid}, 32'd1);
    ea = 32'h4;
    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", imem_addr, ea);
      ea += 32'd4;
      cyc();
    end
    drain(20);

    // back-pressure fills the queue and stalls requests
    rst_seq();
    push_exp(32'h0); push_exp(32'h4);
    for (int i = 0; i < 5; i++) cyc();
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_valid", {31'b0, fetch_valid}, 32'd1);
    chk("stall_head", instruction_out, 32'h0 ^ K);
    chk("stall_pc4", PC_plus4_out, 32'h4);
    chk("stall_addr", imem_addr, 32'h8);
    PC_Write = 1'b1;
    for (int i = 2; i < 7; i++) push_exp(32'(i * 4));
    drain(30);

    // branch during a wait-stated access
    rst_seq();
    PC_Write = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    for (int i = 0; i < 20 && imem_addr != 32'h10; i++) cyc();
    chk("reach_10", imem_addr, 32'h10);
    imem_ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h40;
    sb.delete();
    cyc();
    Branch_Taken = 1'b0;
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_valid", {31'b0, fetch_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("drain_addr", imem_addr, 32'h10);
      cyc();
    end
    chk("drain_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    push_exp(32'h40); push_exp(32'h44);
    cyc();
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", {31'b0, fetch_valid}, 32'd0);
    drain(20);

    // branch beats jump
    rst_seq();
    Branch_Taken = 1'b1; Branch_Target = 32'h80;
    Jump = 1'b1; Jump_Target = 32'h200;
    cyc();
    Branch_Taken = 1'b0; Jump = 1'b0;
    chk("prio_addr", imem_addr, 32'h80);
    PC_Write = 1'b1;
    push_exp(32'h80); push_exp(32'h84);
    drain(20);

    // address wrap
    rst_seq();
    Jump = 1'b1; Jump_Target = 32'hFFFF_FFFC;
    cyc();
    Jump = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    PC_Write = 1'b1;
    push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    cyc();
    chk("wrap_next", imem_addr, 32'h0);
    drain(20);

    // reset mid-request with one entry queued
    rst_seq();
    cyc();
    chk("pre_valid", {31'b0, fetch_valid}, 32'd1);
    chk("pre_req", {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b0;
    rst_seq();
    PC_Write = 1'b1;
    push_exp(32'h0); push_exp(32'h4);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
